seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller for the board display chain. Takes a packed hex-nibble bus with per-digit decimal-point and blank masks, double-buffers it to prevent tearing mid-frame, and time-multiplexes the digits onto an active-low digit-enable bus and an active-low shared segment bus. Sits between the counter/timer datapaths and the board LED pins, and generalises the fixed 8-digit scanner to any digit count, scan rate and full hex range.

## Interface
- DIGITS, 8, number of digits scanned (2..16)
- SCAN_DIV, 200000, clk cycles each digit is held (≥2)
- CNT_W, $clog2(SCAN_DIV), width of the dwell counter (derived, not overridden)

- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse: begin or restart scanning at digit 0
- stop  input  1  one-cycle pulse: stop scanning, all digits off
- load  input  1  one-cycle pulse: capture data/dp/blank into the pending buffer
- data  input  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
- dp  input  DIGITS  decimal point on for digit i when 1
- blank  input  DIGITS  digit i dark when 1
- led_en  output  DIGITS  digit enables, active-low, bit i drives digit i
- led_cx  output  8  segments, active-low, {a,b,c,d,e,f,g,dp} = bits 7..0
- frame_done  output  1  one-cycle pulse when the last digit's dwell ends
- busy  output  1  1 while in SCAN

## Operation
- States: IDLE, SCAN. Reset → IDLE.
- IDLE: led_en all 1, led_cx 8'hFF, counter and digit index held at 0.
- IDLE --start--> SCAN, index 0, counter 0. SCAN --stop--> IDLE. start in SCAN: restart at index 0, counter 0. start and stop in the same cycle: stop wins.
- SCAN: counter increments each cycle; at SCAN_DIV-1 it clears and index advances; DIGITS-1 wraps to 0 and raises frame_done for that cycle.
- Buffers: load copies data/dp/blank into pending and sets pending_valid. Shadow (displayed) is updated from pending at each wrap when pending_valid, or in the cycle after load while in IDLE. A load in the wrap cycle is applied at that wrap. A second load before the wrap overwrites pending (last wins).
- Reset clears shadow and pending to data=0, dp=0, blank=all 1 (dark until first load).
- Decode (active-low): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 A=11 b=C1 C=63 d=85 E=61 F=71 (hex). dp[i]=1 clears bit 0. blank[i]=1 forces 8'hFF (dp also off); led_en bit still asserted.
- led_en in SCAN: only bit index low.

## Timing
- All outputs are registered. led_en/led_cx reflect the index and shadow one cycle after the index changes; the first digit appears 1 cycle after start, and each digit is held exactly SCAN_DIV cycles.
- frame_done: asserted in the cycle the counter wraps from SCAN_DIV-1 with index DIGITS-1; coincident with the shadow update.
- busy: 1 from the cycle after start to the cycle after stop.
- stop: outputs return to all-1/8'hFF one cycle after stop; no frame_done is generated.
- rst mid-scan: immediate IDLE, outputs at reset values asynchronously, pending_valid cleared.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. Scanning from digit DIGITS-1 downward, zero-nibble digits are shown as 8'hFF until the first nonzero nibble or dp=1 digit is reached. Digit 0 is never blanked by this rule. The rule is evaluated on shadow.
- Undefined: every non-blanked digit shows its nibble, including leading zeros.

## Test plan
- DIGITS=8, SCAN_DIV=4, reset, load data=32'h0000_2404, start → led_en steps FE,FD,FB…7F, with each value held for 4 cycles; digit 0 led_cx=99, digit1=03, digit2=99, digit3=25; frame_done pulses every 32 cycles.
- Load 32'hFEDC_BA98 mid-frame → old values until wrap; new values from the frame_done cycle+1; digit7=71, digit0=01.
- dp=8'h01, blank=8'h80 → digit0 led_cx=00 for nibble 8; digit7 8'hFF with led_en bit 7 low.
- start and stop in the same cycle during SCAN → IDLE, led_en=FF, led_cx=FF, no frame_done; start in SCAN at index 5 → index 0 next cycle.
- SEG_LZB_EN, data=32'h0000_0120 → digits 7..3 =FF, digit2=9F; data=0 → only digit0 shows 03.
- rst asserted at index 3 → led_en=FF, led_cx=FF immediately; after release, IDLE until start.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered display data.
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int SCAN_DIV = 200000,
    localparam int CNT_W = $clog2(SCAN_DIV)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     led_en,
    output logic [7:0]            led_cx,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     cnt;

    logic [4*DIGITS-1:0]  pend_data;
    logic [DIGITS-1:0]    pend_dp;
    logic [DIGITS-1:0]    pend_blank;
    logic                 pend_valid;

    logic [4*DIGITS-1:0]  shd_data;
    logic [DIGITS-1:0]    shd_dp;
    logic [DIGITS-1:0]    shd_blank;

    logic                 last_cnt;
    logic                 last_idx;
    logic                 wrap;

    assign last_cnt = (cnt == CNT_W'(SCAN_DIV - 1));
    assign last_idx = (idx == IDX_W'(DIGITS - 1));
    // start/stop override the natural frame end, so no wrap then
    assign wrap = (state == SCAN) && last_cnt && last_idx && !start && !stop;
    assign busy = (state == SCAN);

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        s = 8'hFF;
        case (n)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            4'hF: s = 8'h71;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else if (stop) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else if (start) begin
            state <= SCAN;
            idx   <= '0;
            cnt   <= '0;
        end else if (state == SCAN) begin
            if (last_cnt) begin
                cnt <= '0;
                idx <= last_idx ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_valid <= 1'b0;
            shd_data   <= '0;
            shd_dp     <= '0;
            shd_blank  <= '1;
        end else begin
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp;
                pend_blank <= blank;
            end
            if (wrap) begin
                // a load landing on the wrap itself goes straight to display
                if (load) begin
                    shd_data  <= data;
                    shd_dp    <= dp;
                    shd_blank <= blank;
                end else if (pend_valid) begin
                    shd_data  <= pend_data;
                    shd_dp    <= pend_dp;
                    shd_blank <= pend_blank;
                end
                pend_valid <= 1'b0;
            end else if (state == IDLE && pend_valid) begin
                shd_data   <= pend_data;
                shd_dp     <= pend_dp;
                shd_blank  <= pend_blank;
                pend_valid <= load;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    logic [DIGITS-1:0] lz;

`ifdef SEG_LZB_EN
    logic lead;
    always_comb begin
        lz   = '0;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead  = lead && (shd_data[4*i +: 4] == 4'h0) && !shd_dp[i];
            lz[i] = lead;
        end
    end
`else
    assign lz = '0;
`endif

    logic [3:0]        nib;
    logic              dot;
    logic              dark;
    logic [DIGITS-1:0] next_en;
    logic [7:0]        next_cx;

    always_comb begin
        nib     = shd_data[4*int'(idx) +: 4];
        dot     = shd_dp[idx];
        dark    = shd_blank[idx] | lz[idx];
        next_en = '1;
        next_cx = 8'hFF;
        if (state == SCAN) begin
            next_en[idx] = 1'b0;
            if (!dark) begin
                next_cx = seg7(nib) & {7'h7F, ~dot};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en     <= '1;
            led_cx     <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            led_en     <= next_en;
            led_cx     <= next_cx;
            frame_done <= wrap;
        end
    end

endmodule
